mem_xfer_status_tracker: RTL

- Parametrised successor to the transaction FSM's transfer-completion poller.
- Counts completed SPI data transfers against a total latched at start.
- Optionally polls the flash status register until the WIP bit clears, with an inter-poll gap and a timeout.
- Sits between the transaction FSM and the SPI controller; reports ready, done and timeout back to the FSM.

---
 rtl/mem_xfer_status_tracker.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_xfer_status_tracker.sv
// rtl/mem_xfer_status_tracker.sv - transfer completion counter with WIP status polling and timeout
// Counts SPI data transfers against a latched total, then optionally polls flash status until WIP clears.
module mem_xfer_status_tracker #(
  parameter int CNT_W          = 8,
  parameter int WIP_BIT        = 0,
  parameter int POLL_GAP       = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_start,
  input  logic [CNT_W-1:0] in_total_transfers,
  input  logic             in_wip_poll,
  input  logic             in_abort,
  input  logic             in_xfer_done,
  output logic             out_status_req,
  input  logic             in_status_ack,
  input  logic             in_status_valid,
  input  logic [7:0]       in_status_data,
  output logic             out_ready,
  output logic             out_done,
  output logic             out_timeout,
  output logic [CNT_W-1:0] out_completed
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_POLL_REQ, S_POLL_WAIT, S_POLL_GAP, S_DONE, S_ERROR
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_total;
  logic [CNT_W-1:0]   r_completed;
  logic               r_wip_mode;
  logic [GAP_W-1:0]   r_gap;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_status_req;
  logic               r_ready;
  logic               r_done;
  logic               r_timeout;

  logic [CNT_W-1:0]   w_completed_inc;
  logic [TO_W-1:0]    w_to_inc;
  logic               w_in_poll;
  logic               w_to_hit;
  logic               w_wip_clear;

  assign w_completed_inc = r_completed + CNT_W'(1);
  assign w_in_poll       = (r_state == S_POLL_REQ) || (r_state == S_POLL_WAIT) ||
                           (r_state == S_POLL_GAP);
  assign w_to_inc        = (r_to_cnt == {TO_W{1'b1}}) ? r_to_cnt : r_to_cnt + TO_W'(1);
  assign w_to_hit        = w_in_poll && (w_to_inc >= TO_LIMIT);
  assign w_wip_clear     = in_status_valid && !in_status_data[WIP_BIT];

  assign out_status_req = r_status_req;
  assign out_ready      = r_ready;
  assign out_done       = r_done;
  assign out_timeout    = r_timeout;
  assign out_completed  = r_completed;

  // Outputs are registered alongside the state so they change on the same edge as the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_total      <= '0;
      r_completed  <= '0;
      r_wip_mode   <= 1'b0;
      r_gap        <= '0;
      r_to_cnt     <= '0;
      r_status_req <= 1'b0;
      r_ready      <= 1'b1;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (in_abort) begin
        r_state      <= S_IDLE;
        r_status_req <= 1'b0;
        r_ready      <= 1'b1;
      end else begin
        if (w_in_poll) r_to_cnt <= w_to_inc;
        case (r_state)
          S_IDLE: begin
            if (in_start) begin
              r_total     <= in_total_transfers;
              r_wip_mode  <= in_wip_poll;
              r_completed <= '0;
              r_to_cnt    <= '0;
              r_timeout   <= 1'b0;
              r_ready     <= 1'b0;
              if (in_total_transfers != '0) begin
                r_state <= S_COUNT;
              end else if (in_wip_poll) begin
                r_state      <= S_POLL_REQ;
                r_status_req <= 1'b1;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
          S_COUNT: begin
            if (in_xfer_done) begin
              r_completed <= w_completed_inc;
              if (w_completed_inc == r_total) begin
                if (r_wip_mode) begin
                  r_state      <= S_POLL_REQ;
                  r_status_req <= 1'b1;
                end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end
              end
            end
          end
          S_POLL_REQ: begin
            if (w_to_hit) begin
              r_state      <= S_ERROR;
              r_status_req <= 1'b0;
              r_done       <= 1'b1;
              r_timeout    <= 1'b1;
            end else if (in_status_ack) begin
              r_state      <= S_POLL_WAIT;
              r_status_req <= 1'b0;
            end
          end
          S_POLL_WAIT: begin
            // A clean status reply in the timeout cycle still completes normally.
            if (w_wip_clear) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (w_to_hit) begin
              r_state   <= S_ERROR;
              r_done    <= 1'b1;
              r_timeout <= 1'b1;
            end else if (in_status_valid) begin
              r_gap   <= GAP_LOAD;
              r_state <= S_POLL_GAP;
            end
          end
          S_POLL_GAP: begin
            if (w_to_hit) begin
              r_state   <= S_ERROR;
              r_done    <= 1'b1;
              r_timeout <= 1'b1;
            end else if (r_gap == '0) begin
              r_state      <= S_POLL_REQ;
              r_status_req <= 1'b1;
            end else begin
              r_gap <= r_gap - GAP_W'(1);
            end
          end
          S_DONE, S_ERROR: begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
          default: begin
            r_state      <= S_IDLE;
            r_status_req <= 1'b0;
            r_ready      <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
